// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the multiplier arbiter: credit-gate states,
// round-robin pick, and tag/ctl packing (tag in LSBs, requester ctl above it).
package mult_arbiter_pkg;

   localparam int unsigned RR_MAX  = 32;
   localparam int unsigned RR_IW   = $clog2(RR_MAX);
   localparam int unsigned CTL_MAX = 64;

   typedef enum logic {
      CG_OPEN = 1'b0,
      CG_FULL = 1'b1
   } credit_state_e;

   // One-hot grant to the first set bit of req at or after ptr, wrapping at n.
   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                 input int unsigned       ptr,
                                                 input int unsigned       n);
      logic [RR_MAX-1:0] gnt;
      logic [RR_IW-1:0]  idx;
      gnt = '0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         idx = RR_IW'((ptr + k) % n);
         if (k < n && gnt == '0 && req[idx]) gnt[idx] = 1'b1;
      end
      return gnt;
   endfunction

   function automatic logic [CTL_MAX-1:0] pack_ctl(input logic [CTL_MAX-1:0] ctl,
                                                   input logic [CTL_MAX-1:0] tag,
                                                   input int unsigned        tag_bits);
      return (ctl << tag_bits) | tag;
   endfunction

   function automatic logic [CTL_MAX-1:0] tag_of(input logic [CTL_MAX-1:0] pctl,
                                                 input int unsigned        tag_bits);
      return pctl & ((64'd1 << tag_bits) - 64'd1);
   endfunction

   function automatic logic [CTL_MAX-1:0] ctl_of(input logic [CTL_MAX-1:0] pctl,
                                                 input int unsigned        tag_bits);
      return pctl >> tag_bits;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick from the registered pointer;
// the pointer moves past the winner only when the advance strobe is high.
module rr_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [N-1:0]  i_req,
   input  logic          i_adv,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_ptr
);

   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gnt_idx;
   logic [RR_MAX-1:0] pick_w;
   logic              unused_pick_hi;

   always_comb begin
      pick_w         = rr_pick(RR_MAX'(i_req), 32'(ptr_q), N);
      o_grant        = pick_w[N-1:0];
      unused_pick_hi = |pick_w[RR_MAX-1:N];
      gnt_idx        = '0;
      for (int i = 0; i < N; i++) begin
         if (o_grant[i]) gnt_idx = PW'(i);
      end
      ptr_d = ptr_q;
      if (i_adv && |o_grant) begin
         ptr_d = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

   assign o_ptr = ptr_q;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier among NUM_REQ requesters: round-robin issue
// slot, tagged results routed back through one response register, credit-bounded.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = 4,
   parameter  int unsigned OP_BITS      = 258,
   parameter  int unsigned RES_BITS     = 516,
   parameter  int unsigned CTL_BITS     = 8,
   parameter  int unsigned MAX_INFLIGHT = 8,
   localparam int unsigned TAG_BITS     = $clog2(NUM_REQ),
   localparam int unsigned CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_REQ-1:0]              i_req_val,
   input  logic [NUM_REQ*2*OP_BITS-1:0]    i_req_dat,
   input  logic [NUM_REQ*CTL_BITS-1:0]     i_req_ctl,
   output logic [NUM_REQ-1:0]              o_req_rdy,
   output logic                            o_mul_val,
   output logic [2*OP_BITS-1:0]            o_mul_dat,
   output logic [CTL_BITS+TAG_BITS-1:0]    o_mul_ctl,
   input  logic                            i_mul_rdy,
   input  logic                            i_mul_val,
   input  logic [RES_BITS-1:0]             i_mul_dat,
   input  logic [CTL_BITS+TAG_BITS-1:0]    i_mul_ctl,
   output logic                            o_mul_rdy,
   output logic [NUM_REQ-1:0]              o_rsp_val,
   output logic [RES_BITS-1:0]             o_rsp_dat,
   output logic [CTL_BITS-1:0]             o_rsp_ctl,
   input  logic [NUM_REQ-1:0]              i_rsp_rdy,
   output credit_state_e                   o_dbg_state,
   output logic [CNT_BITS-1:0]             o_dbg_inflight,
   output logic [TAG_BITS-1:0]             o_dbg_rr_ptr
);

   // Every channel is valid/ready: a transfer happens on the edge where both
   // are high; a valid source holds its payload unchanged until that edge.
   localparam int unsigned DAT_BITS  = 2 * OP_BITS;
   localparam int unsigned MCTL_BITS = CTL_BITS + TAG_BITS;

   credit_state_e        state_q, state_d;
   logic [CNT_BITS-1:0]  inflight_q, inflight_d;
   logic                 mul_val_q, mul_val_d;
   logic [DAT_BITS-1:0]  mul_dat_q, mul_dat_d;
   logic [MCTL_BITS-1:0] mul_ctl_q, mul_ctl_d;
   logic [NUM_REQ-1:0]   rsp_val_q, rsp_val_d;
   logic [RES_BITS-1:0]  rsp_dat_q, rsp_dat_d;
   logic [CTL_BITS-1:0]  rsp_ctl_q, rsp_ctl_d;
   logic [TAG_BITS-1:0]  rsp_tag_q, rsp_tag_d;

   logic                 slot_free, can_issue, grant_any;
   logic                 rsp_full, mul_cap, rsp_drain;
   logic [NUM_REQ-1:0]   req_gated, grant_oh;
   logic [DAT_BITS-1:0]  sel_dat;
   logic [CTL_BITS-1:0]  sel_ctl;
   logic [TAG_BITS-1:0]  sel_tag;
   logic [CTL_MAX-1:0]   pack_w, cap_tag_w, cap_ctl_w;
   logic                 unused_ctl_hi;

   always_comb begin
      slot_free = !mul_val_q || i_mul_rdy;
      can_issue = slot_free && (state_q == CG_OPEN);
      req_gated = can_issue ? i_req_val : '0;
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (req_gated),
      .i_adv   (grant_any),
      .o_grant (grant_oh),
      .o_ptr   (o_dbg_rr_ptr)
   );

   assign grant_any = |grant_oh;
   assign o_req_rdy = grant_oh;

   // Issue slot: a new grant overwrites the slot only when it is free.
   always_comb begin
      sel_dat = '0;
      sel_ctl = '0;
      sel_tag = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_dat = i_req_dat[i*DAT_BITS +: DAT_BITS];
            sel_ctl = i_req_ctl[i*CTL_BITS +: CTL_BITS];
            sel_tag = TAG_BITS'(i);
         end
      end
      pack_w    = pack_ctl(CTL_MAX'(sel_ctl), CTL_MAX'(sel_tag), TAG_BITS);
      mul_val_d = mul_val_q;
      mul_dat_d = mul_dat_q;
      mul_ctl_d = mul_ctl_q;
      if (grant_any) begin
         mul_val_d = 1'b1;
         mul_dat_d = sel_dat;
         mul_ctl_d = pack_w[MCTL_BITS-1:0];
      end else if (i_mul_rdy) begin
         mul_val_d = 1'b0;
      end
   end

   // Response register: accepts a result when empty or draining this cycle.
   always_comb begin
      rsp_full  = |rsp_val_q;
      o_mul_rdy = !rsp_full || i_rsp_rdy[rsp_tag_q];
      mul_cap   = i_mul_val && o_mul_rdy;
      rsp_drain = |(rsp_val_q & i_rsp_rdy);
      cap_tag_w = tag_of(CTL_MAX'(i_mul_ctl), TAG_BITS);
      cap_ctl_w = ctl_of(CTL_MAX'(i_mul_ctl), TAG_BITS);
      rsp_val_d = rsp_val_q;
      rsp_dat_d = rsp_dat_q;
      rsp_ctl_d = rsp_ctl_q;
      rsp_tag_d = rsp_tag_q;
      if (mul_cap) begin
         rsp_val_d = NUM_REQ'(1) << cap_tag_w[TAG_BITS-1:0];
         rsp_dat_d = i_mul_dat;
         rsp_ctl_d = cap_ctl_w[CTL_BITS-1:0];
         rsp_tag_d = cap_tag_w[TAG_BITS-1:0];
      end else if (rsp_drain) begin
         rsp_val_d = '0;
      end
      unused_ctl_hi = |{pack_w[CTL_MAX-1:MCTL_BITS], cap_tag_w[CTL_MAX-1:TAG_BITS],
                        cap_ctl_w[CTL_MAX-1:CTL_BITS]};
   end

   // Credit counter and the OPEN/FULL gate derived from it.
   always_comb begin
      inflight_d = inflight_q;
      if (grant_any && !rsp_drain)      inflight_d = inflight_q + 1'b1;
      else if (!grant_any && rsp_drain) inflight_d = inflight_q - 1'b1;
      state_d = state_q;
      case (state_q)
         CG_OPEN: if (inflight_d == CNT_BITS'(MAX_INFLIGHT)) state_d = CG_FULL;
         CG_FULL: if (inflight_d != CNT_BITS'(MAX_INFLIGHT)) state_d = CG_OPEN;
         default: state_d = CG_OPEN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= CG_OPEN;
         inflight_q <= '0;
         mul_val_q  <= 1'b0;
         mul_dat_q  <= '0;
         mul_ctl_q  <= '0;
         rsp_val_q  <= '0;
         rsp_dat_q  <= '0;
         rsp_ctl_q  <= '0;
         rsp_tag_q  <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         mul_val_q  <= mul_val_d;
         mul_dat_q  <= mul_dat_d;
         mul_ctl_q  <= mul_ctl_d;
         rsp_val_q  <= rsp_val_d;
         rsp_dat_q  <= rsp_dat_d;
         rsp_ctl_q  <= rsp_ctl_d;
         rsp_tag_q  <= rsp_tag_d;
      end
   end

   assign o_mul_val      = mul_val_q;
   assign o_mul_dat      = mul_dat_q;
   assign o_mul_ctl      = mul_ctl_q;
   assign o_rsp_val      = rsp_val_q;
   assign o_rsp_dat      = rsp_dat_q;
   assign o_rsp_ctl      = rsp_ctl_q;
   assign o_dbg_state    = state_q;
   assign o_dbg_inflight = inflight_q;

   // A result with nothing outstanding means the multiplier and this block disagree.
   a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !((mul_cap || (rsp_drain && !grant_any)) && inflight_q == '0));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed phases with random operands for mult_arbiter, checked every cycle
// against a queue-based model of requesters, the multiplier and the response path.
module tb_mult_arbiter;

   localparam int NR   = 4;
   localparam int OPB  = 258;
   localparam int RB   = 516;
   localparam int CB   = 8;
   localparam int TB   = 2;
   localparam int MAXI = 8;
   localparam int LAT  = 3;

   logic                  i_clk, i_rst_n;
   logic [NR-1:0]         i_req_val, o_req_rdy;
   logic [NR*2*OPB-1:0]   i_req_dat;
   logic [NR*CB-1:0]      i_req_ctl;
   logic                  o_mul_val, i_mul_rdy, i_mul_val, o_mul_rdy;
   logic [2*OPB-1:0]      o_mul_dat;
   logic [CB+TB-1:0]      o_mul_ctl, i_mul_ctl;
   logic [RB-1:0]         i_mul_dat, o_rsp_dat;
   logic [NR-1:0]         o_rsp_val, i_rsp_rdy;
   logic [CB-1:0]         o_rsp_ctl;
   mult_arbiter_pkg::credit_state_e o_dbg_state;
   logic [3:0]            o_dbg_inflight;
   logic [TB-1:0]         o_dbg_rr_ptr;

   mult_arbiter dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_val(i_req_val), .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .o_req_rdy(o_req_rdy),
      .o_mul_val(o_mul_val), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .i_mul_rdy(i_mul_rdy),
      .i_mul_val(i_mul_val), .i_mul_dat(i_mul_dat), .i_mul_ctl(i_mul_ctl), .o_mul_rdy(o_mul_rdy),
      .o_rsp_val(o_rsp_val), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl), .i_rsp_rdy(i_rsp_rdy),
      .o_dbg_state(o_dbg_state), .o_dbg_inflight(o_dbg_inflight), .o_dbg_rr_ptr(o_dbg_rr_ptr)
   );

   // ---------------- clock ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- model state ----------------
   typedef struct { logic [OPB-1:0] a; logic [OPB-1:0] b; logic [CB-1:0] ctl; } op_t;
   typedef struct { logic [OPB-1:0] a; logic [OPB-1:0] b; logic [CB-1:0] ctl; int tag; } iss_t;
   typedef struct { logic [RB-1:0] res; logic [CB+TB-1:0] mctl; int due; } mres_t;

   op_t               req_q[NR][$];
   logic [CB+RB-1:0]  exp_q[NR][$];
   iss_t              iss_q[$];
   mres_t             mul_q[$];
   logic [RB-1:0]     log_q[$];
   int                gnt_log[$];

   int n_pass, n_chk, cyc;
   int ptr_m, infl_m, rt_m;
   bit mv_m, rv_m;
   int mul_mode, rsp_mode;
   logic [NR-1:0] req_en, rsp_mask, last_gnt;
   int dut_grants, dut_drains, both_cnt;

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic logic [OPB-1:0] rand_op();
      logic [287:0] w;
      case ($urandom_range(0, 3))
         0: return '1;
         1: return OPB'($urandom_range(0, 255));
         default: begin
            for (int k = 0; k < 9; k++) w[k*32 +: 32] = $urandom;
            return w[OPB-1:0];
         end
      endcase
   endfunction

   task automatic load(input int r, input logic [OPB-1:0] a, input logic [OPB-1:0] b,
                       input logic [CB-1:0] c);
      op_t o;
      o.a = a; o.b = b; o.ctl = c;
      req_q[r].push_back(o);
   endtask

   task automatic load_rand(input int per_req);
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < per_req; k++)
            load(r, rand_op(), rand_op(), CB'($urandom_range(0, 255)));
   endtask

   function automatic int busy();
      int s;
      s = iss_q.size() + mul_q.size() + int'(rv_m) + int'(mv_m);
      for (int r = 0; r < NR; r++) s += req_q[r].size() + exp_q[r].size();
      return s;
   endfunction

   task automatic clear_model();
      for (int r = 0; r < NR; r++) begin req_q[r].delete(); exp_q[r].delete(); end
      iss_q.delete(); mul_q.delete();
      ptr_m = 0; infl_m = 0; rt_m = 0; mv_m = 0; rv_m = 0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req_rdy"}, o_req_rdy, '0);
      chk({tag, "_mul_val"}, o_mul_val, 1'b0);
      chk({tag, "_mul_dat"}, o_mul_dat, '0);
      chk({tag, "_mul_ctl"}, o_mul_ctl, '0);
      chk({tag, "_mul_rdy"}, o_mul_rdy, 1'b1);
      chk({tag, "_rsp_val"}, o_rsp_val, '0);
      chk({tag, "_rsp_dat"}, o_rsp_dat, '0);
      chk({tag, "_rsp_ctl"}, o_rsp_ctl, '0);
      chk({tag, "_inflight"}, o_dbg_inflight, 0);
      chk({tag, "_rr_ptr"}, o_dbg_rr_ptr, 0);
   endtask

   // One clock: drive at the falling edge, check, advance the model, wait one cycle.
   task automatic step();
      logic [NR-1:0] exp_gnt;
      logic [CB+RB-1:0] e;
      iss_t it;
      mres_t m;
      bit acc, cap, drn;
      int idx, g;
      for (int i = 0; i < NR; i++) begin
         i_req_val[i] = req_en[i] && (req_q[i].size() > 0);
         if (i_req_val[i]) begin
            i_req_dat[i*2*OPB +: 2*OPB] = {req_q[i][0].b, req_q[i][0].a};
            i_req_ctl[i*CB +: CB]       = req_q[i][0].ctl;
         end else begin
            i_req_dat[i*2*OPB +: 2*OPB] = '0;
            i_req_ctl[i*CB +: CB]       = '0;
         end
      end
      case (mul_mode)
         0: i_mul_rdy = 1'b1;
         1: i_mul_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: i_mul_rdy = 1'($urandom_range(0, 1));
      endcase
      i_mul_val = (mul_q.size() > 0) && (mul_q[0].due <= cyc);
      i_mul_dat = i_mul_val ? mul_q[0].res : '0;
      i_mul_ctl = i_mul_val ? mul_q[0].mctl : '0;
      i_rsp_rdy = (rsp_mode == 0) ? rsp_mask : NR'($urandom_range(0, 15));
      #1;
      exp_gnt = '0;
      if ((!mv_m || i_mul_rdy) && infl_m < MAXI) begin
         for (int k = 0; k < NR; k++) begin
            idx = (ptr_m + k) % NR;
            if (exp_gnt == '0 && i_req_val[idx]) exp_gnt[idx] = 1'b1;
         end
      end
      chk("req_rdy", o_req_rdy, exp_gnt);
      chk("mul_val", o_mul_val, mv_m);
      if (mv_m) begin
         chk("mul_dat", o_mul_dat, {iss_q[0].b, iss_q[0].a});
         chk("mul_ctl", o_mul_ctl, {iss_q[0].ctl, TB'(iss_q[0].tag)});
      end
      chk("rsp_val", o_rsp_val, rv_m ? (NR'(1) << rt_m) : NR'(0));
      if (rv_m && exp_q[rt_m].size() > 0) begin
         e = exp_q[rt_m][0];
         chk("rsp_dat", o_rsp_dat, e[RB-1:0]);
         chk("rsp_ctl", o_rsp_ctl, e[CB+RB-1:RB]);
      end
      chk("mul_rdy", o_mul_rdy, !rv_m || i_rsp_rdy[rt_m]);
      chk("inflight", o_dbg_inflight, infl_m);
      chk("state", o_dbg_state, infl_m == MAXI);
      chk("rr_ptr", o_dbg_rr_ptr, ptr_m);
      last_gnt = o_req_rdy;
      for (int i = 0; i < NR; i++) if (o_req_rdy[i]) gnt_log.push_back(i);
      if (|o_req_rdy) dut_grants++;
      if (|(o_rsp_val & i_rsp_rdy)) dut_drains++;

      acc = mv_m && i_mul_rdy;
      drn = rv_m && i_rsp_rdy[rt_m];
      cap = i_mul_val && (!rv_m || i_rsp_rdy[rt_m]);
      if (drn && cap) both_cnt++;
      if (drn) begin
         e = exp_q[rt_m].pop_front();
         if (rt_m == 2) log_q.push_back(e[RB-1:0]);
      end
      if (acc) begin
         it = iss_q.pop_front();
         m.res  = RB'(it.a) * RB'(it.b);
         m.mctl = {it.ctl, TB'(it.tag)};
         m.due  = cyc + LAT;
         mul_q.push_back(m);
      end
      if (cap) begin
         m = mul_q.pop_front();
         rv_m = 1; rt_m = int'(m.mctl[TB-1:0]);
      end else if (drn) rv_m = 0;
      if (|exp_gnt) begin
         g = 0;
         for (int i = 0; i < NR; i++) if (exp_gnt[i]) g = i;
         it.a = req_q[g][0].a; it.b = req_q[g][0].b; it.ctl = req_q[g][0].ctl; it.tag = g;
         void'(req_q[g].pop_front());
         iss_q.push_back(it);
         exp_q[g].push_back({it.ctl, RB'(it.a) * RB'(it.b)});
         ptr_m = (g + 1) % NR;
         mv_m = 1;
      end else if (acc) mv_m = 0;
      infl_m = infl_m + int'(|exp_gnt) - int'(drn);
      @(posedge i_clk);
      cyc++;
      @(negedge i_clk);
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy() != 0 && n < budget) begin step(); n++; end
      chk({tag, "_idle"}, busy(), 0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      n_pass = 0; n_chk = 0; cyc = 0; both_cnt = 0;
      i_rst_n = 1'b0; i_req_val = '0; i_req_dat = '0; i_req_ctl = '0;
      i_mul_rdy = 1'b0; i_mul_val = 1'b0; i_mul_dat = '0; i_mul_ctl = '0; i_rsp_rdy = '0;
      req_en = '1; rsp_mask = '1; mul_mode = 0; rsp_mode = 0; last_gnt = '0;
      clear_model();
      @(negedge i_clk);
      #1 check_reset("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // all requesters busy, latency-3 multiplier always ready
      load_rand(5);
      gnt_log.delete();
      run_until_idle("t1", 300);
      for (int k = 0; k < 8; k++) chk("t1_order", gnt_log[k], k % NR);

      // requester 2 alone with small operands
      req_en = 4'b0100; log_q.delete();
      load(2, OPB'(3), OPB'(5), 8'h22);
      load(2, OPB'(7), OPB'(11), 8'h23);
      run_until_idle("t2", 100);
      chk("t2_count", log_q.size(), 2);
      chk("t2_first", log_q[0], 15);
      chk("t2_second", log_q[1], 77);
      chk("t2_ptr", o_dbg_rr_ptr, 3);

      // responses blocked: credit limit, then a single drain frees one slot
      req_en = '1; rsp_mask = '0; dut_grants = 0;
      load_rand(5);
      for (int k = 0; k < 40; k++) step();
      chk("t3_grants", dut_grants, 8);
      rsp_mask = '1; step(); rsp_mask = '0;
      for (int k = 0; k < 20; k++) step();
      chk("t3_grants_after", dut_grants, 9);
      rsp_mask = '1;
      run_until_idle("t3", 400);

      // multiplier ready pattern 1,0,0,1
      mul_mode = 1; dut_grants = 0; dut_drains = 0;
      load_rand(3);
      run_until_idle("t4", 400);
      chk("t4_grants", dut_grants, 12);
      chk("t4_drains", dut_drains, 12);

      // random back-pressure on both sides
      mul_mode = 2; rsp_mode = 1;
      load_rand(8);
      run_until_idle("t5", 3000);
      chk("b2b_seen", both_cnt > 0, 1'b1);

      // reset with five operations outstanding
      mul_mode = 0; rsp_mode = 0; rsp_mask = '0;
      load_rand(5);
      for (int k = 0; k < 50 && infl_m < 5; k++) step();
      chk("t6_outstanding", o_dbg_inflight, 5);
      #2;
      i_rst_n = 1'b0; i_req_val = '0; i_mul_val = 1'b0; i_rsp_rdy = '0;
      #1 check_reset("t6_reset");
      clear_model();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1; rsp_mask = '1;
      load_rand(2);
      step();
      chk("t6_first_grant", last_gnt, 4'b0001);
      run_until_idle("t6", 300);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one external multiplier among `NUM_REQ` modular-arithmetic requesters, such as reduction units configured to use an external multiplier. Each requester presents operand pairs over a valid/ready handshake. The block issues one operation per cycle to the multiplier, tags it with the requester index, and routes each tagged result back to its owner through a registered response stage. A global in-flight credit counter bounds outstanding operations, so results can never overrun the response stage.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `OP_BITS`, 258: width of each operand.
- `RES_BITS`, 516: width of a multiplier result.
- `CTL_BITS`, 8: requester-private control, carried unchanged with the operation.
- `MAX_INFLIGHT`, 8: maximum number of accepted operations whose result has not yet been delivered.
- `TAG_BITS`, `$clog2(NUM_REQ)`: derived; not overridden.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_req_val`  in  NUM_REQ  per-requester request valid.
- `i_req_dat`  in  NUM_REQ*2*OP_BITS  per-requester `{b,a}`; slice i at `[i*2*OP_BITS +: 2*OP_BITS]`.
- `i_req_ctl`  in  NUM_REQ*CTL_BITS  per-requester control.
- `o_req_rdy`  out  NUM_REQ  one-hot-or-zero grant.
- `o_mul_val`, `o_mul_dat` [2*OP_BITS], `o_mul_ctl` [CTL_BITS+TAG_BITS]  out: multiplier request, `ctl = {req_ctl, tag}`.
- `i_mul_rdy`  in  1  multiplier accepts a request.
- `i_mul_val`, `i_mul_dat` [RES_BITS], `i_mul_ctl` [CTL_BITS+TAG_BITS]  in: multiplier result; the multiplier returns ctl unchanged.
- `o_mul_rdy`  out  1  result accept.
- `o_rsp_val`  out  NUM_REQ  one-hot-or-zero response valid.
- `o_rsp_dat` [RES_BITS], `o_rsp_ctl` [CTL_BITS]  out: shared response bus.
- `i_rsp_rdy`  in  NUM_REQ  per-requester response ready.

## Operation
**Issue stage** (one register slot)
- The slot is free when `!o_mul_val || i_mul_rdy`.
- Credit is available when `inflight < MAX_INFLIGHT`.
- When the slot is free and credit is available, the grant goes to the first requester with `i_req_val` set, searching from `rr_ptr` upward modulo `NUM_REQ`.
- `o_req_rdy` is that one-hot grant, combinational from `i_req_val`, `rr_ptr`, the slot state and `inflight`. Otherwise `o_req_rdy` is 0.
- On a grant to requester g, on the next edge:
  - data and `{ctl,g}` load into the slot and `o_mul_val` is set to 1;
  - `rr_ptr` becomes `(g+1) mod NUM_REQ`.
- If no requester is valid, `rr_ptr` is unchanged.
- `o_mul_val` clears when `i_mul_rdy` is seen and there is no new grant.

**Response stage** (one register)
- `o_mul_rdy = !rsp_full || i_rsp_rdy[rsp_tag]`.
- On `i_mul_val && o_mul_rdy`, the stage captures the result, `ctl[CTL_BITS+TAG_BITS-1:TAG_BITS]` and the tag, and sets `o_rsp_val[tag]`.
- Drain occurs on `o_rsp_val[t] && i_rsp_rdy[t]`. Back-to-back drain and capture in the same cycle is supported.

**Credit counter** `inflight` (width `$clog2(MAX_INFLIGHT+1)`)
- +1 on a grant.
- −1 on a response drain.
- Both in the same cycle: unchanged.
- It never exceeds `MAX_INFLIGHT` and never underflows. An underflow means a result arrived with no outstanding operation; it raises a simulation assertion.

**State machine** (credit gate): `OPEN` (`inflight < MAX_INFLIGHT`) ↔ `FULL` (`inflight == MAX_INFLIGHT`). In `FULL`, all `o_req_rdy` are held at 0.

## Timing
- Reset values: `o_req_rdy=0`, `o_mul_val=0`, `o_mul_dat=0`, `o_mul_ctl=0`, `o_mul_rdy=1`, `o_rsp_val=0`, `o_rsp_dat=0`, `o_rsp_ctl=0`. Internal: `rr_ptr=0`, `inflight=0`.
- Arbiter latency: grant at cycle t gives `o_mul_val` at t+1. A result captured at cycle u gives `o_rsp_val` at u+1.
- Throughput: one issue per cycle while `i_mul_rdy=1` and credit remains. One response per cycle while the addressed `i_rsp_rdy=1`.
- Handshakes:
  - `o_mul_val` and its data are stable until `i_mul_rdy` is seen.
  - `o_rsp_*` is stable until drained.
  - Requesters must hold `i_req_*` until `o_req_rdy`.
- Fairness: a continuously valid requester is granted within `NUM_REQ` grants.
- Reset mid-operation: all state clears asynchronously and in-flight operations are lost. The multiplier and all requesters must share `i_rst_n`.

## Structure
- The shared package holds:
  - the tag/ctl packing helpers: tag in the LSBs, requester ctl in the MSBs;
  - the one-hot round-robin pick function `rr_pick(req, ptr)`, returning a one-hot vector.
- One sub-module, `rr_arbiter` (parameter `N`): combinational pick plus the registered `rr_ptr`, with an advance strobe. The issue, response and credit logic stay in the top level.

## Test plan
1. `NUM_REQ=4`, all requesters continuously valid, multiplier with `i_mul_rdy=1` and fixed latency 3 → grants issued in order 0,1,2,3,0…; each response returns `a*b` with the originating ctl to its own requester.
2. Only requester 2 valid with ops `(3,5)` and `(7,11)` → responses `15` then `77` on `o_rsp_val[2]` only; `rr_ptr` advances to 3 after each grant.
3. `i_rsp_rdy=0` for every requester, 20 requests offered → exactly 8 grants, `o_req_rdy` is 0 thereafter. After one response is drained, exactly one further grant is made.
4. `i_mul_rdy` toggling 1,0,0,1 → `o_mul_dat` and `o_mul_ctl` are held stable while stalled, and no request is lost or duplicated (scoreboard count matches).
5. Response drain and new capture in the same cycle → `inflight` is unchanged and there is no bubble on `o_rsp_val`.
6. `i_rst_n` asserted with 5 operations outstanding → all outputs take their reset values immediately. After release, the first grant goes to requester 0.
